// File: rtl/soc_ic_pkg.sv
// ============================================================================
// Module   : soc_ic_pkg
// Brief    : Shared types, arbitration-mode constants and sizing helper for
//            the soc_ic interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package soc_ic_pkg;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_REQ     = 2'd1,
        IC_SERVICE = 2'd2,
        IC_FINISH  = 2'd3
    } ic_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Index width for n sources; a single source still needs a 1-bit id.
    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/soc_ic_prio_sel.sv
// ============================================================================
// Module   : soc_ic_prio_sel
// Brief    : Combinational find-first-set starting at a rotating base index,
//            wrapping modulo N. A base of zero gives plain lowest-index wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_ic_prio_sel
    import soc_ic_pkg::*;
#(
    parameter int N = 32,
    parameter int W = id_w(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] base,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [N-1:0] w_rot;
    logic [W-1:0] w_off;
    logic [W:0]   w_sum;

    // Rotating right by base puts the search origin at bit 0.
    assign w_rot = N'({vec, vec} >> base);

    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = W'(k);
            end
        end
    end

    assign w_sum = {1'b0, base} + {1'b0, w_off};
    assign idx   = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : w_sum[W-1:0];
    assign valid = |vec;

endmodule

`default_nettype wire

// File: rtl/soc_ic_arb.sv
// ============================================================================
// Module   : soc_ic_arb
// Brief    : N-source interrupt controller with edge/level capture, pending
//            vector, fixed or round-robin arbitration and claim/complete FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_ic_arb
    import soc_ic_pkg::*;
#(
    parameter int               N_SRC     = 32,
    parameter logic [N_SRC-1:0] EDGE_MASK = '0,
    parameter int               ARB_MODE  = ARB_FIXED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] mie_i,
    input  logic             int_rst_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_SRC-1:0] int_fin_o,
    output logic [N_SRC-1:0] int_pending_o,
    input  logic [N_SRC-1:0] int_req_i
);

    localparam int               c_id_w = id_w(N_SRC);
    localparam logic [c_id_w-1:0] c_last = c_id_w'(N_SRC - 1);
    localparam logic [N_SRC-1:0]  c_one  = N_SRC'(1);

    ic_state_e         r_state;
    logic [c_id_w-1:0] r_cur_id;
    logic [c_id_w-1:0] r_last_id;
    logic              r_int_o;
    logic [N_SRC-1:0]  r_fin;
    logic [N_SRC-1:0]  r_req_q;
    logic [N_SRC-1:0]  r_pend_edge;

    logic [N_SRC-1:0]  w_pending;
    logic [N_SRC-1:0]  w_eligible;
    logic [N_SRC-1:0]  w_edge_set;
    logic [N_SRC-1:0]  w_edge_clr;
    logic [c_id_w-1:0] w_base;
    logic              w_win_valid;
    logic [c_id_w-1:0] w_win_id;

    // Edge sources latch into r_pend_edge; level sources pass straight through.
    assign w_edge_set = int_req_i & ~r_req_q & EDGE_MASK;
    assign w_pending  = r_pend_edge | (int_req_i & ~EDGE_MASK);
    assign w_eligible = w_pending & mie_i;

    always_comb begin
        w_edge_clr = '0;
        if (r_state == IC_FINISH) begin
            w_edge_clr = EDGE_MASK & (c_one << r_cur_id);
        end
    end

    always_comb begin
        w_base = '0;
        if (ARB_MODE == ARB_RR && r_last_id != c_last) begin
            w_base = r_last_id + c_id_w'(1);
        end
    end

    soc_ic_prio_sel #(
        .N (N_SRC),
        .W (c_id_w)
    ) u_prio_sel (
        .vec   (w_eligible),
        .base  (w_base),
        .valid (w_win_valid),
        .idx   (w_win_id)
    );

    // A new edge in the same cycle as the FINISH clear keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_q     <= '0;
            r_pend_edge <= '0;
        end else begin
            r_req_q     <= int_req_i;
            r_pend_edge <= ((r_pend_edge & ~w_edge_clr) | w_edge_set) & EDGE_MASK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IC_IDLE;
            r_cur_id  <= '0;
            r_last_id <= c_last;
            r_int_o   <= 1'b0;
            r_fin     <= '0;
        end else begin
            r_int_o <= 1'b0;
            r_fin   <= '0;
            unique case (r_state)
                IC_IDLE: begin
                    if (w_win_valid) begin
                        r_cur_id <= w_win_id;
                        r_int_o  <= 1'b1;
                        r_state  <= IC_REQ;
                    end
                end
                IC_REQ: begin
                    if (int_rst_i) begin
                        r_fin   <= c_one << r_cur_id;
                        r_state <= IC_FINISH;
                    end else begin
                        r_state <= IC_SERVICE;
                    end
                end
                IC_SERVICE: begin
                    if (int_rst_i) begin
                        r_fin   <= c_one << r_cur_id;
                        r_state <= IC_FINISH;
                    end
                end
                IC_FINISH: begin
                    r_last_id <= r_cur_id;
                    r_state   <= IC_IDLE;
                end
                default: r_state <= IC_IDLE;
            endcase
        end
    end

    assign int_o         = r_int_o;
    assign int_fin_o     = r_fin;
    assign int_pending_o = w_pending;
    assign mcause_o      = 32'(r_cur_id);

endmodule

`default_nettype wire
